// File: rtl/if_id_skid_stage.sv
// Fetch-to-decode pipeline register with valid/ready handshake, stall, flush
// and a one-entry skid buffer so ready_o depends only on registered state.
module if_id_skid_stage #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] instr_i,
  input  logic [WIDTH-1:0] pc_plus4_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic [1:0]       occupancy_o
);

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } entry_t;

  localparam entry_t NOP_ENTRY = {NOP_INSTR, {WIDTH{1'b0}}};

  state_t state, state_next;
  entry_t main_q, main_next;
  entry_t skid_q, skid_next;
  entry_t in_entry_c;
  logic   in_fire_c;
  logic   out_fire_c;

  assign in_entry_c = {instr_i, pc_plus4_i};
  assign in_fire_c  = valid_i & ready_o;
  assign out_fire_c = valid_o & ready_i & ~stall_i;

  // Next-state and datapath selection; flush overrides every other event.
  always_comb begin
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    if (flush_i) begin
      state_next = EMPTY;
      main_next  = NOP_ENTRY;
      skid_next  = NOP_ENTRY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire_c) begin
            main_next  = in_entry_c;
            state_next = ONE;
          end
        end
        ONE: begin
          if (in_fire_c && out_fire_c) begin
            main_next = in_entry_c;
          end else if (in_fire_c) begin
            skid_next  = in_entry_c;
            state_next = FULL;
          end else if (out_fire_c) begin
            main_next  = NOP_ENTRY;
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_fire_c) begin
            main_next  = skid_q;
            skid_next  = NOP_ENTRY;
            state_next = ONE;
          end
        end
        default: begin
          state_next = EMPTY;
          main_next  = NOP_ENTRY;
          skid_next  = NOP_ENTRY;
        end
      endcase
    end
  end

  // State, payload and status flags, all registered from the next state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= EMPTY;
      main_q      <= NOP_ENTRY;
      skid_q      <= NOP_ENTRY;
      valid_o     <= 1'b0;
      ready_o     <= 1'b1;
      occupancy_o <= '0;
    end else begin
      state       <= state_next;
      main_q      <= main_next;
      skid_q      <= skid_next;
      valid_o     <= (state_next != EMPTY);
      ready_o     <= (state_next != FULL);
      occupancy_o <= OCC_W'(state_next);
    end
  end

  assign instr_o    = main_q.instr;
  assign pc_plus4_o = main_q.pc;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: 32-bit and 16-bit instances share control inputs
// and are compared against a queue-based model of the held entries.
module tb_if_id_skid_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        valid_i, ready_i, stall_i, flush_i;
  logic [31:0] instr, pc;
  logic [15:0] instr16, pc16;

  logic        ready_a, valid_a;
  logic [31:0] instr_a, pc_a;
  logic [1:0]  occ_a;
  logic        ready_b, valid_b;
  logic [15:0] instr_b, pc_b;
  logic [1:0]  occ_b;

  ent_t q[$];
  int   tests  = 0;
  int   failed = 0;

  assign instr16 = instr[15:0];
  assign pc16    = pc[15:0];

  always #5 clk = ~clk;

  if_id_skid_stage #(.WIDTH(32), .NOP_INSTR(32'h0000_0000)) dut32 (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_a),
    .instr_i(instr), .pc_plus4_i(pc), .stall_i(stall_i), .flush_i(flush_i),
    .valid_o(valid_a), .ready_i(ready_i), .instr_o(instr_a),
    .pc_plus4_o(pc_a), .occupancy_o(occ_a)
  );

  if_id_skid_stage #(.WIDTH(16), .NOP_INSTR(16'hFFFF)) dut16 (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_b),
    .instr_i(instr16), .pc_plus4_i(pc16), .stall_i(stall_i), .flush_i(flush_i),
    .valid_o(valid_b), .ready_i(ready_i), .instr_o(instr_b),
    .pc_plus4_o(pc_b), .occupancy_o(occ_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [31:0] ei, ep;
    logic [15:0] ei16, ep16;
    n    = q.size();
    ei   = (n > 0) ? q[0].instr : 32'h0000_0000;
    ep   = (n > 0) ? q[0].pc    : 32'h0;
    ei16 = (n > 0) ? ei[15:0] : 16'hFFFF;
    ep16 = ep[15:0];
    chk({tag, ".valid32"}, 32'(valid_a), 32'(n > 0));
    chk({tag, ".ready32"}, 32'(ready_a), 32'(n < 2));
    chk({tag, ".occ32"},   32'(occ_a),   32'(n));
    chk({tag, ".instr32"}, instr_a, ei);
    chk({tag, ".pc32"},    pc_a,    ep);
    chk({tag, ".valid16"}, 32'(valid_b), 32'(n > 0));
    chk({tag, ".occ16"},   32'(occ_b),   32'(n));
    chk({tag, ".instr16"}, 32'(instr_b), 32'(ei16));
    chk({tag, ".pc16"},    32'(pc_b),    32'(ep16));
  endtask

  // One clock: apply inputs, advance the model across the edge, then check.
  task automatic step(input string tag, input logic vi, input logic [31:0] ins,
                      input logic ri, input logic st, input logic fl);
    bit in_f, out_f;
    ent_t e;
    valid_i = vi; instr = ins; pc = ins + 32'd4;
    ready_i = ri; stall_i = st; flush_i = fl;
    in_f  = vi && (q.size() < 2);
    out_f = (q.size() > 0) && ri && !st;
    e.instr = ins; e.pc = ins + 32'd4;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(e);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0; ready_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    instr = '0; pc = '0;
    #2;
    check_all("reset");
    chk("reset.ready16", 32'(ready_b), 32'd1);
    chk("reset.nop16", 32'(instr_b), 32'h0000_FFFF);
    @(posedge clk); #1;
    reset_i = 1'b0;

    // streaming at full rate
    step("stream0", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    chk("stream0.instr", instr_a, 32'h100);
    step("stream1", 1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
    chk("stream1.occ", 32'(occ_a), 32'd1);
    step("stream2", 1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
    chk("stream2.instr16", 32'(instr_b), 32'h0108);
    step("stream_drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // backpressure fills skid, then stall, then drain
    step("bp_a1", 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    step("bp_a2", 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    chk("bp.full_instr", instr_a, 32'hA1);
    chk("bp.full_ready", 32'(ready_a), 32'd0);
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("stall.hold", instr_a, 32'hA1);
    step("drain1", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drain1.instr", instr_a, 32'hA2);
    step("drain2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // flush while full with a same-cycle input
    step("fl_a1", 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    step("fl_a2", 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    step("flush", 1'b1, 32'hB0, 1'b1, 1'b0, 1'b1);
    chk("flush.valid", 32'(valid_a), 32'd0);
    step("post_flush", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("post_flush.instr", instr_a, 32'h0);

    // asynchronous reset while full
    step("rs_a1", 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    step("rs_a2", 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    reset_i = 1'b1;
    #2;
    q.delete();
    check_all("async_reset");
    chk("async_reset.ready", 32'(ready_a), 32'd1);
    #1;
    reset_i = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
